// File: rtl/instruction_fetch.sv
// Instruction fetch for a mixed 16/32-bit ISA: reads 16-bit words, uses bit 15 of the
// first word to decide whether a second word follows, and hands the result to decode.
module instruction_fetch #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_data,
    input  logic                branch_valid,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [31:0]         fetchoutput,
    output logic                fetch_is32,
    output logic [PC_WIDTH-1:0] fetch_pc,
    output logic                fetch_valid,
    input  logic                decode_ready
);

    typedef enum logic [1:0] {
        FETCH,
        LOW,
        HIGH,
        HOLD
    } state_t;

    state_t              state_reg;
    logic [PC_WIDTH-1:0] pc_reg;
    logic [31:0]         instr_reg;
    logic                is32_reg;
    logic                valid_reg;

    logic [PC_WIDTH-1:0] pc_plus1;
    logic [PC_WIDTH-1:0] pc_next;
    logic                second_req;

    // The second-word request is issued in the same cycle the first word arrives,
    // unless a redirect lands in that cycle.
    assign pc_plus1   = pc_reg + PC_WIDTH'(1);
    assign pc_next    = pc_reg + (is32_reg ? PC_WIDTH'(2) : PC_WIDTH'(1));
    assign second_req = (state_reg == LOW) && imem_data[15] && !branch_valid;

    assign imem_req  = (state_reg == FETCH) || second_req;
    assign imem_addr = second_req ? pc_plus1 : pc_reg;

    assign fetchoutput = instr_reg;
    assign fetch_is32  = is32_reg;
    assign fetch_pc    = pc_reg;
    assign fetch_valid = valid_reg;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC;
            instr_reg <= '0;
            is32_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else if (branch_valid) begin
            // Redirect wins over everything, including a handshake in HOLD.
            state_reg <= FETCH;
            pc_reg    <= branch_target;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                FETCH: begin
                    state_reg <= LOW;
                end
                LOW: begin
                    instr_reg[15:0] <= imem_data;
                    is32_reg        <= imem_data[15];
                    if (imem_data[15]) begin
                        state_reg <= HIGH;
                    end else begin
                        instr_reg[31:16] <= 16'h0000;
                        state_reg        <= HOLD;
                        valid_reg        <= 1'b1;
                    end
                end
                HIGH: begin
                    instr_reg[31:16] <= imem_data;
                    state_reg        <= HOLD;
                    valid_reg        <= 1'b1;
                end
                HOLD: begin
                    if (decode_ready) begin
                        pc_reg    <= pc_next;
                        state_reg <= FETCH;
                        valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= FETCH;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural 1-cycle instruction memory, a scoreboard of
// expected instructions checked on every decode handshake, and per-scenario timing checks.
module tb_instruction_fetch;

    localparam int PW = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic [15:0]   imem_data;
    logic          branch_valid;
    logic [PW-1:0] branch_target;
    logic [31:0]   fetchoutput;
    logic          fetch_is32;
    logic [PW-1:0] fetch_pc;
    logic          fetch_valid;
    logic          decode_ready;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0]   instr;
        logic          is32;
        logic [PW-1:0] pc;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mem [0:65535];

    instruction_fetch #(
        .PC_WIDTH(PW),
        .RESET_PC(16'h0000)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .fetchoutput  (fetchoutput),
        .fetch_is32   (fetch_is32),
        .fetch_pc     (fetch_pc),
        .fetch_valid  (fetch_valid),
        .decode_ready (decode_ready)
    );

    always #5 clock = ~clock;

    // Memory answers one cycle after a request; unrequested cycles return junk.
    always @(posedge clock) begin
        imem_data <= imem_req ? mem[imem_addr] : 16'h0BAD;
    end

    // Scoreboard: every accepted instruction must match the oldest expectation.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && fetch_valid === 1'b1 && decode_ready === 1'b1) begin
            exp_t e;
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: accepted instr=%h pc=%h, required no instruction",
                         fetchoutput, fetch_pc);
            end else begin
                e = sb_q.pop_front();
                if (fetchoutput !== e.instr || fetch_is32 !== e.is32 || fetch_pc !== e.pc) begin
                    n_fail++;
                    $display("FAIL sb_instr: got instr=%h is32=%b pc=%h, required instr=%h is32=%b pc=%h",
                             fetchoutput, fetch_is32, fetch_pc, e.instr, e.is32, e.pc);
                end else begin
                    $display("[TB] accept pc=%h instr=%h is32=%0d", fetch_pc, fetchoutput, fetch_is32);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic is32, input logic [PW-1:0] pc);
        exp_t e;
        e.instr = instr;
        e.is32  = is32;
        e.pc    = pc;
        sb_q.push_back(e);
    endtask

    task automatic apply_reset(input logic ready);
        reset_n      = 1'b0;
        branch_valid = 1'b0;
        decode_ready = ready;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic redirect(input logic [PW-1:0] target);
        branch_valid  = 1'b1;
        branch_target = target;
        step();
        branch_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, input string tag);
        int i;
        i = 0;
        while (fetch_valid !== 1'b1 && i < max_cycles) begin
            step();
            i++;
        end
        n_tests++;
        if (fetch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: fetch_valid=%b after %0d cycles, required 1", tag, fetch_valid, max_cycles);
        end
    endtask

    task automatic test_reset();
        mem[0] = 16'h5555;
        mem[1] = 16'h0000;
        reset_n       = 1'b0;
        branch_valid  = 1'b1;
        branch_target = 16'h0123;
        decode_ready  = 1'b1;
        step();
        step();
        n_tests++;
        if ({fetch_valid, fetch_is32, fetchoutput, fetch_pc} !== {1'b0, 1'b0, 32'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b is32=%b out=%h pc=%h, required 0 0 00000000 0000",
                     fetch_valid, fetch_is32, fetchoutput, fetch_pc);
        end
        branch_valid = 1'b0;
        push(32'h0000_5555, 1'b0, 16'h0000);
        reset_n = 1'b1;
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_first_req: req=%b addr=%h, required 1 0000", imem_req, imem_addr);
        end
        step();
        n_tests++;
        if ({imem_req, fetch_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_low16: req=%b valid=%b, required 0 0", imem_req, fetch_valid);
        end
        step();
        n_tests++;
        if (fetch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_latency: valid=%b in cycle 2, required 1", fetch_valid);
        end
        step();
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0001}) begin
            n_fail++;
            $display("FAIL reset_next_req: req=%b addr=%h, required 1 0001", imem_req, imem_addr);
        end
        decode_ready = 1'b0;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_drain: %0d undelivered, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_32bit();
        mem[4] = 16'h8123;
        mem[5] = 16'h8456;
        mem[6] = 16'h0000;
        push(32'h8456_8123, 1'b1, 16'h0004);
        apply_reset(1'b1);
        redirect(16'h0004);
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0004}) begin
            n_fail++;
            $display("FAIL w32_first_req: req=%b addr=%h, required 1 0004", imem_req, imem_addr);
        end
        step();
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0005}) begin
            n_fail++;
            $display("FAIL w32_second_req: req=%b addr=%h, required 1 0005", imem_req, imem_addr);
        end
        step();
        n_tests++;
        if ({imem_req, fetch_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL w32_high: req=%b valid=%b, required 0 0", imem_req, fetch_valid);
        end
        step();
        n_tests++;
        if (fetch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL w32_latency: valid=%b in cycle 3, required 1", fetch_valid);
        end
        step();
        n_tests++;
        if ({imem_req, imem_addr, fetch_pc} !== {1'b1, 16'h0006, 16'h0006}) begin
            n_fail++;
            $display("FAIL w32_next: req=%b addr=%h pc=%h, required 1 0006 0006", imem_req, imem_addr, fetch_pc);
        end
        decode_ready = 1'b0;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL w32_drain: %0d undelivered, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_stall();
        mem[0] = 16'h1234;
        mem[1] = 16'h0000;
        push(32'h0000_1234, 1'b0, 16'h0000);
        apply_reset(1'b0);
        wait_valid(10, "stall");
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if ({fetch_valid, fetchoutput, fetch_is32, fetch_pc, imem_req} !==
                {1'b1, 32'h0000_1234, 1'b0, 16'h0000, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold cyc%0d: valid=%b out=%h is32=%b pc=%h req=%b, required 1 00001234 0 0000 0",
                         c, fetch_valid, fetchoutput, fetch_is32, fetch_pc, imem_req);
            end
            step();
        end
        decode_ready = 1'b1;
        step();
        n_tests++;
        if ({fetch_valid, imem_req, imem_addr, fetch_pc} !== {1'b0, 1'b1, 16'h0001, 16'h0001}) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b req=%b addr=%h pc=%h, required 0 1 0001 0001",
                     fetch_valid, imem_req, imem_addr, fetch_pc);
        end
        decode_ready = 1'b0;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_drain: %0d undelivered, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_branch_high();
        mem[0]     = 16'h8AAA;
        mem[1]     = 16'h1111;
        mem[16'h0100] = 16'h0777;
        mem[16'h0101] = 16'h0000;
        push(32'h0000_0777, 1'b0, 16'h0100);
        apply_reset(1'b1);
        step();
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0001}) begin
            n_fail++;
            $display("FAIL brh_low_req: req=%b addr=%h, required 1 0001", imem_req, imem_addr);
        end
        step();
        redirect(16'h0100);
        n_tests++;
        if ({fetch_valid, imem_req, imem_addr, fetch_pc} !== {1'b0, 1'b1, 16'h0100, 16'h0100}) begin
            n_fail++;
            $display("FAIL brh_redirect: valid=%b req=%b addr=%h pc=%h, required 0 1 0100 0100",
                     fetch_valid, imem_req, imem_addr, fetch_pc);
        end
        wait_valid(10, "brh");
        step();
        decode_ready = 1'b0;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL brh_drain: %0d undelivered, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_branch_handshake();
        mem[16'h0010] = 16'h0010;
        mem[16'h0011] = 16'h0BAD;
        mem[16'h0040] = 16'h0040;
        mem[16'h0041] = 16'h0000;
        push(32'h0000_0010, 1'b0, 16'h0010);
        push(32'h0000_0040, 1'b0, 16'h0040);
        apply_reset(1'b0);
        redirect(16'h0010);
        wait_valid(10, "bhs_first");
        decode_ready  = 1'b1;
        branch_valid  = 1'b1;
        branch_target = 16'h0040;
        step();
        branch_valid = 1'b0;
        decode_ready = 1'b0;
        n_tests++;
        if ({fetch_valid, imem_req, imem_addr, fetch_pc} !== {1'b0, 1'b1, 16'h0040, 16'h0040}) begin
            n_fail++;
            $display("FAIL bhs_target: valid=%b req=%b addr=%h pc=%h, required 0 1 0040 0040",
                     fetch_valid, imem_req, imem_addr, fetch_pc);
        end
        wait_valid(10, "bhs_second");
        decode_ready = 1'b1;
        step();
        decode_ready = 1'b0;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL bhs_drain: %0d undelivered, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_wrap();
        mem[16'hFFFF] = 16'h8001;
        mem[0]        = 16'h9002;
        mem[1]        = 16'h0003;
        mem[2]        = 16'h0000;
        push(32'h9002_8001, 1'b1, 16'hFFFF);
        push(32'h0000_0003, 1'b0, 16'h0001);
        apply_reset(1'b1);
        redirect(16'hFFFF);
        step();
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL wrap_second_req: req=%b addr=%h, required 1 0000", imem_req, imem_addr);
        end
        wait_valid(10, "wrap_first");
        step();
        n_tests++;
        if ({imem_req, imem_addr, fetch_pc} !== {1'b1, 16'h0001, 16'h0001}) begin
            n_fail++;
            $display("FAIL wrap_pc: req=%b addr=%h pc=%h, required 1 0001 0001", imem_req, imem_addr, fetch_pc);
        end
        wait_valid(10, "wrap_second");
        step();
        decode_ready = 1'b0;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_drain: %0d undelivered, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        mem[16'h0020] = 16'h8000;
        mem[16'h0021] = 16'h4444;
        mem[0]        = 16'h0033;
        mem[1]        = 16'h0000;
        apply_reset(1'b1);
        redirect(16'h0020);
        step();
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0021}) begin
            n_fail++;
            $display("FAIL rmid_low_req: req=%b addr=%h, required 1 0021", imem_req, imem_addr);
        end
        reset_n       = 1'b0;
        branch_valid  = 1'b1;
        branch_target = 16'h0055;
        step();
        n_tests++;
        if ({fetch_valid, fetch_pc, fetchoutput, fetch_is32} !== {1'b0, 16'h0000, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL rmid_state: valid=%b pc=%h out=%h is32=%b, required 0 0000 00000000 0",
                     fetch_valid, fetch_pc, fetchoutput, fetch_is32);
        end
        branch_valid = 1'b0;
        push(32'h0000_0033, 1'b0, 16'h0000);
        reset_n = 1'b1;
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL rmid_restart: req=%b addr=%h, required 1 0000", imem_req, imem_addr);
        end
        wait_valid(10, "rmid");
        step();
        decode_ready = 1'b0;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL rmid_drain: %0d undelivered, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int gaps [6];
        int prev;
        int got;
        gaps = '{2, 3, 3, 4, 4, 3};
        mem[0] = 16'h0101;
        mem[1] = 16'h0102;
        mem[2] = 16'h0103;
        mem[3] = 16'h8104;
        mem[4] = 16'h8105;
        mem[5] = 16'h8106;
        mem[6] = 16'h0107;
        mem[7] = 16'h0108;
        mem[8] = 16'h0000;
        push(32'h0000_0101, 1'b0, 16'h0000);
        push(32'h0000_0102, 1'b0, 16'h0001);
        push(32'h0000_0103, 1'b0, 16'h0002);
        push(32'h8105_8104, 1'b1, 16'h0003);
        push(32'h0107_8106, 1'b1, 16'h0005);
        push(32'h0000_0108, 1'b0, 16'h0007);
        apply_reset(1'b1);
        prev = 0;
        got  = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (fetch_valid === 1'b1) begin
                n_tests++;
                if (c - prev != gaps[got]) begin
                    n_fail++;
                    $display("FAIL b2b_gap%0d: valid after %0d cycles, required %0d", got, c - prev, gaps[got]);
                end
                prev = c;
                got++;
            end
            step();
        end
        decode_ready = 1'b0;
        n_tests++;
        if (got != 6) begin
            n_fail++;
            $display("FAIL b2b_count: %0d instructions seen, required 6", got);
        end
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: %0d undelivered, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 16'h0000;
        end
        reset_n       = 1'b0;
        branch_valid  = 1'b0;
        branch_target = '0;
        decode_ready  = 1'b0;
        test_reset();
        test_32bit();
        test_stall();
        test_branch_high();
        test_branch_handshake();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
